// File: rtl/dot_product_sched_pkg.sv
// Shared state encoding and size derivations for the dot-product sequencer.
package dot_product_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_OUT
  } state_t;

  // Floored at 1 so a single-valued counter or index still has a real bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int beats_of(input int pixel_n, input int lanes);
    return (pixel_n + lanes - 1) / lanes;
  endfunction

  function automatic int addr_width_of(input int neuron_n, input int beats);
    return clog2(neuron_n * beats);
  endfunction

  function automatic int idx_width_of(input int neuron_n);
    return clog2(neuron_n);
  endfunction

endpackage

// File: rtl/dp_sched_lane_mux.sv
// Beat-k lane selector: lane j carries pixel k*LANES+j from the latched vector.
// Pixel and weight lanes are zeroed past PIXEL_N and whenever en is low.
module dp_sched_lane_mux
  import dot_product_sched_pkg::*;
#(
  parameter int PIXEL_N     = 10,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int LANES       = 1,
  parameter int BW          = 4
) (
  input  logic                          en,
  input  logic [BW-1:0]                 beat,
  input  logic [PIXEL_N*PIXEL_SIZE-1:0] px,
  input  logic [LANES*WEIGHT_SIZE-1:0]  w_rdata,
  output logic [LANES*PIXEL_SIZE-1:0]   pixels,
  output logic [LANES*WEIGHT_SIZE-1:0]  weights
);

  always_comb begin
    pixels  = '0;
    weights = '0;
    for (int j = 0; j < LANES; j++) begin
      int p;
      p = int'(beat) * LANES + j;
      if (en && (p < PIXEL_N)) begin
        pixels[j*PIXEL_SIZE +: PIXEL_SIZE]    = px[p*PIXEL_SIZE +: PIXEL_SIZE];
        weights[j*WEIGHT_SIZE +: WEIGHT_SIZE] = w_rdata[j*WEIGHT_SIZE +: WEIGHT_SIZE];
      end
    end
  end

endmodule

// File: rtl/dot_product_sched.sv
// Runs one layer on DotProductSt per neuron: clear, stream BEATS beats, drain, present result.
// Result valid 2+BEATS+DRAIN_CYCLES cycles after start/accept; out_valid holds value/index until out_ready.
module dot_product_sched
  import dot_product_sched_pkg::*;
#(
  parameter int PIXEL_N      = 10,
  parameter int PIXEL_SIZE   = 10,
  parameter int WEIGHT_SIZE  = 19,
  parameter int VAL_SIZE     = 26,
  parameter int PARALLEL     = 1,
  parameter int BUS_WIDTH    = 1,
  parameter int NEURON_N     = 4,
  parameter int DRAIN_CYCLES = 11,
  localparam int L     = PARALLEL * BUS_WIDTH,
  localparam int BEATS = beats_of(PIXEL_N, L),
  localparam int AW    = addr_width_of(NEURON_N, BEATS),
  localparam int NW    = idx_width_of(NEURON_N)
) (
  input  logic                          clk,
  input  logic                          GlobalReset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [PIXEL_N*PIXEL_SIZE-1:0] px_in,
  output logic                          w_en,
  output logic [AW-1:0]                 w_addr,
  input  logic [L*WEIGHT_SIZE-1:0]      w_rdata,
  output logic                          dp_clear,
  output logic [L*PIXEL_SIZE-1:0]       dp_pixels,
  output logic [L*WEIGHT_SIZE-1:0]      dp_weights,
  input  logic [VAL_SIZE-1:0]           dp_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VAL_SIZE-1:0]           out_value,
  output logic [NW-1:0]                 out_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int BW = clog2(BEATS);
  localparam int DW = clog2(DRAIN_CYCLES);
  localparam logic [NW-1:0] LAST_N = NW'(NEURON_N - 1);

  state_t                        state;
  state_t                        state_nxt;
  logic [BW-1:0]                 beat;
  logic [DW-1:0]                 drain;
  logic [NW-1:0]                 n;
  logic [PIXEL_N*PIXEL_SIZE-1:0] px_q;
  logic                          abort_q;
  logic                          feeding;
  logic                          feed_last;
  logic                          drain_last;
  logic                          accept;
  logic                          last_n;
  logic [AW-1:0]                 base_addr;

  assign feeding    = (state == ST_FEED);
  assign feed_last  = (beat == BW'(BEATS - 1));
  assign drain_last = (drain == '0);
  assign accept     = (state == ST_OUT) & out_ready;
  assign last_n     = (n == LAST_N);
  assign base_addr  = AW'(n) * AW'(BEATS);

  assign busy     = (state != ST_IDLE);
  // abort_q stretches the accumulator clear into the first IDLE cycle after a cancel.
  assign dp_clear = (state == ST_CLEAR) | abort_q;

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    w_en      = 1'b0;
    w_addr    = '0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        state_nxt = ST_FEED;
        w_en      = 1'b1;
        w_addr    = base_addr;
      end
      ST_FEED: begin
        // Reads run one beat ahead of the data they feed.
        if (feed_last) begin
          state_nxt = ST_DRAIN;
        end else begin
          w_en   = 1'b1;
          w_addr = base_addr + AW'(beat) + AW'(1);
        end
      end
      ST_DRAIN: if (drain_last) state_nxt = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_n ? ST_IDLE : ST_CLEAR;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      beat      <= '0;
      drain     <= '0;
      n         <= '0;
      px_q      <= '0;
      abort_q   <= 1'b0;
      out_value <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      abort_q <= abort;
      done    <= accept & last_n & ~abort;
      beat    <= feeding ? beat + 1'b1 : '0;

      if (feeding) begin
        drain <= DW'(DRAIN_CYCLES - 1);
      end else if ((state == ST_DRAIN) && !drain_last) begin
        drain <= drain - 1'b1;
      end

      if ((state == ST_IDLE) && start && !abort) begin
        px_q <= px_in;
        n    <= '0;
      end else if (accept && !last_n && !abort) begin
        n <= n + 1'b1;
      end

      if ((state == ST_DRAIN) && drain_last && !abort) begin
        out_value <= dp_value;
        out_idx   <= n;
      end
    end
  end

  dp_sched_lane_mux #(
    .PIXEL_N    (PIXEL_N),
    .PIXEL_SIZE (PIXEL_SIZE),
    .WEIGHT_SIZE(WEIGHT_SIZE),
    .LANES      (L),
    .BW         (BW)
  ) u_lane_mux (
    .en     (feeding),
    .beat   (beat),
    .px     (px_q),
    .w_rdata(w_rdata),
    .pixels (dp_pixels),
    .weights(dp_weights)
  );

endmodule
